bcd_to_binary_ctrl: RTL and testbench
=====================================

Name: bcd_to_binary_ctrl

Overview:
- Sequential, handshaked BCD-to-binary converter for multi-digit packed BCD words.
- Converts one digit per clock using the recurrence acc = acc*10 + digit, most significant digit first, and flags any non-decimal nibble.
- Sits between a BCD source (keypad/display datapath) and binary consumers; valid/ready on both sides.

Parameters:
- DIGITS, 4, number of packed BCD digits in the input word (>=1).
- BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)), e.g. 14 for 4 digits, 7 for 2 digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents bcd_in.
- in_ready  output  1  block can accept a word.
- bcd_in  input  4*DIGITS  packed BCD, digit DIGITS-1 in the top nibble.
- out_valid  output  1  binary_out and error are valid.
- out_ready  input  1  consumer accepts the result.
- binary_out  output  BIN_W  converted value.
- error  output  1  at least one nibble > 9 in the accepted word.
- busy  output  1  state != IDLE.

Behaviour:
- Single clock, synchronous active-high reset. All state changes on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, binary_out=0, error=0, busy=0. in_ready=0 while rst=1.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: capture bcd_in into a shift register, clear the accumulator, digit counter and error flag, go to CONVERT.
- CONVERT:
  - in_ready=0.
  - Each cycle take d = top nibble of the shift register.
  - acc <= acc*10 + d, implemented as (acc<<3)+(acc<<1)+d, truncated to BIN_W.
  - err <= err | (d>9).
  - Shift the register left by 4 and increment the counter.
  - After DIGITS cycles, load binary_out (acc, or 0 if err) and error, then go to DONE.
- DONE:
  - out_valid=1; binary_out and error held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, return to IDLE.
  - in_ready=0 throughout DONE.
- Latency: out_valid rises exactly DIGITS cycles after the accepting edge.
- Throughput: one word per DIGITS+2 cycles minimum (accept, DIGITS converts, result handshake, IDLE).
- Arithmetic: no overflow is possible for valid BCD given the BIN_W constraint. On invalid input, wrap is irrelevant because the result is forced to 0 with error=1.
- Boundaries:
  - in_valid while not IDLE: ignored; data not captured.
  - bcd_in changing after acceptance: no effect.
  - out_ready high before out_valid: no effect.
  - out_ready held high: result consumed in the first DONE cycle.
  - rst during CONVERT or DONE: next state IDLE, in-flight word discarded, all outputs at reset values, no out_valid emitted for that word.
  - DIGITS=1: exactly one CONVERT cycle.
  - All-zero input: result 0, error 0.

Test Plan:
- DIGITS=4, bcd_in=16'h1234 accepted at cycle 0 -> out_valid at cycle 4, binary_out=1234 (0x4D2), error=0, busy=1 during cycles 1-4.
- 16'h9999 -> 9999 (0x270F); 16'h0000 -> 0, error=0; 16'h0007 -> 7.
- 16'h12A4 (nibble 0xA) -> binary_out=0, error=1; 16'hF000 -> binary_out=0, error=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> binary_out/error stable, in_ready=0, a new in_valid (16'h5555) is not captured. Raise out_ready -> IDLE next cycle; then 16'h5555 -> 5555.
- rst=1 for one cycle during the 2nd CONVERT cycle of 16'h4321 -> state IDLE next cycle, out_valid=0, busy=0, no result for 4321; then 16'h0042 -> 42, error=0.
- DIGITS=2, BIN_W=7: 8'h99 -> 99, 8'h10 -> 10, 8'h3B -> 0 with error=1; back-to-back words with out_ready tied 1 -> one result every 4 cycles.

Source files
------------

// File: rtl/bcd_to_binary_ctrl.sv
// Handshaked multi-digit packed-BCD to binary converter, one digit per clock,
// most significant digit first; any nibble above 9 forces a zero result with error set.
module bcd_to_binary_ctrl #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  error,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] sr;
    logic [BIN_W-1:0]    acc, acc_nxt;
    logic                err, err_nxt;
    logic [CW-1:0]       cnt;
    logic [3:0]          d;
    logic                last;

    assign d       = sr[4*DIGITS-1 -: 4];
    // acc*10 as two shifts and an add; BIN_W is sized so valid BCD never wraps
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(d);
    assign err_nxt = err | (d > 4'd9);
    assign last    = (cnt == CW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = CONVERT;
            end
            CONVERT: if (last) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            acc        <= '0;
            err        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            binary_out <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr  <= bcd_in;
                    acc <= '0;
                    err <= 1'b0;
                    cnt <= '0;
                end
                CONVERT: begin
                    acc <= acc_nxt;
                    err <= err_nxt;
                    sr  <= sr << 4;
                    cnt <= cnt + 1'b1;
                    // final digit folds in combinationally so the result lands this edge
                    if (last) begin
                        binary_out <= err_nxt ? '0 : acc_nxt;
                        error      <= err_nxt;
                        out_valid  <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_ctrl.sv
// Directed bench: a 4-digit and a 2-digit converter share clock and reset.
module tb_bcd_to_binary_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, error4, busy4;
    logic [15:0] bcd4 = '0;
    logic [13:0] bin4;
    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, error2, busy2;
    logic [7:0]  bcd2 = '0;
    logic [6:0]  bin2;

    int checks = 0;
    int errs   = 0;

    bcd_to_binary_ctrl #(.DIGITS(4), .BIN_W(14)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .bcd_in(bcd4),
        .out_valid(out_valid4), .out_ready(out_ready4), .binary_out(bin4), .error(error4), .busy(busy4));

    bcd_to_binary_ctrl #(.DIGITS(2), .BIN_W(7)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .bcd_in(bcd2),
        .out_valid(out_valid2), .out_ready(out_ready2), .binary_out(bin2), .error(error2), .busy(busy2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // accept one word on the 4-digit unit and wait for its result (left un-consumed)
    task automatic start4(input logic [15:0] w, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready4), 1);
        in_valid4 = 1'b1; bcd4 = w; out_ready4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0; bcd4 = 16'h9876;
        chk({tag, " busy"}, 32'(busy4), 1);
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 4);
    endtask

    task automatic xfer4(input logic [15:0] w, input logic [13:0] ev, input logic ee, input string tag);
        start4(w, tag);
        chk({tag, " value"}, 32'(bin4), 32'(ev));
        chk({tag, " error"}, 32'(error4), 32'(ee));
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk({tag, " drained"}, 32'({out_valid4, busy4}), 0);
    endtask

    task automatic xfer2(input logic [7:0] w, input logic [6:0] ev, input logic ee, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready2), 1);
        in_valid2 = 1'b1; bcd2 = w; out_ready2 = 1'b0;
        @(posedge clk); #1;
        in_valid2 = 1'b0; bcd2 = 8'h00;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 2);
        chk({tag, " value"}, 32'(bin2), 32'(ev));
        chk({tag, " error"}, 32'(error2), 32'(ee));
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        chk({tag, " drained"}, 32'({out_valid2, busy2}), 0);
    endtask

    initial begin
        int seen;
        int last_c;
        int c;

        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 32'({in_ready4, in_ready2}), 0);
        chk("rst out_valid", 32'({out_valid4, out_valid2}), 0);
        chk("rst busy", 32'({busy4, busy2}), 0);
        chk("rst binary_out", 32'(bin4), 0);
        chk("rst error", 32'(error4), 0);
        rst = 1'b0;

        xfer4(16'h1234, 14'd1234, 1'b0, "w1234");
        xfer4(16'h9999, 14'd9999, 1'b0, "w9999");
        xfer4(16'h0000, 14'd0,    1'b0, "w0000");
        xfer4(16'h0007, 14'd7,    1'b0, "w0007");
        xfer4(16'h12A4, 14'd0,    1'b1, "w12A4");
        xfer4(16'hF000, 14'd0,    1'b1, "wF000");

        // backpressure: result must hold and a new word must not be taken
        start4(16'h1234, "bp");
        in_valid4 = 1'b1; bcd4 = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", 32'(out_valid4), 1);
            chk("bp hold value", 32'(bin4), 1234);
            chk("bp in_ready", 32'(in_ready4), 0);
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("bp release", 32'({out_valid4, busy4}), 0);
        xfer4(16'h5555, 14'd5555, 1'b0, "w5555");

        // reset during the second CONVERT cycle discards the word
        @(negedge clk);
        in_valid4 = 1'b1; bcd4 = 16'h4321;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid rst busy", 32'(busy4), 0);
        chk("mid rst out_valid", 32'(out_valid4), 0);
        chk("mid rst in_ready", 32'(in_ready4), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid4) seen++;
        end
        chk("mid rst no result", 32'(seen), 0);
        xfer4(16'h0042, 14'd42, 1'b0, "w0042");

        xfer2(8'h99, 7'd99, 1'b0, "d2 99");
        xfer2(8'h10, 7'd10, 1'b0, "d2 10");
        xfer2(8'h3B, 7'd0,  1'b1, "d2 3B");

        // back-to-back with out_ready tied high: one result every DIGITS+2 cycles
        @(negedge clk);
        in_valid2 = 1'b1; bcd2 = 8'h57; out_ready2 = 1'b1;
        seen = 0; last_c = 0; c = 0;
        while (seen < 3 && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (out_valid2) begin
                chk("b2b value", 32'(bin2), 57);
                if (seen > 0) chk("b2b spacing", 32'(c - last_c), 4);
                last_c = c;
                seen++;
            end
        end
        chk("b2b count", 32'(seen), 3);
        in_valid2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
